// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S receiver. Oversamples the serial link on MasterCLK,
// assembles {left, right} 16-bit frames and queues them in a show-ahead FIFO.
module i2s_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        I2S_CLK,
  input  logic        I2S_WS,
  input  logic        I2S_DATA,
  output logic [31:0] OutputData,
  output logic        OutputValid,
  input  logic        OutputRead,
  input  logic        ClearFlags,
  output logic        Overflow,
  output logic        FrameError
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic bit_evt_q, bit_evt_d;
  logic ws_bit_q, ws_bit_d;
  logic data_bit_q, data_bit_d;

  state_t      state_q, state_d;
  logic        ws_last_q, ws_last_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] left_hold_q, left_hold_d;
  logic        left_ok_q, left_ok_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  logic        ws_change;
  logic [15:0] word;
  logic        push;
  logic        frame_err_set;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        overflow_set;

  // The event is registered together with the sampled WS/DATA so the FSM sees all three aligned.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], I2S_CLK};
    ws_sync_d   = {ws_sync_q[SYNC_STAGES-2:0], I2S_WS};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], I2S_DATA};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    bit_evt_d   = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    ws_bit_d    = bit_evt_d ? ws_sync_q[SYNC_STAGES-1] : ws_bit_q;
    data_bit_d  = bit_evt_d ? data_sync_q[SYNC_STAGES-1] : data_bit_q;
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q  <= '0;
      ws_sync_q   <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      bit_evt_q   <= 1'b0;
      ws_bit_q    <= 1'b0;
      data_bit_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      ws_sync_q   <= ws_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_evt_q   <= bit_evt_d;
      ws_bit_q    <= ws_bit_d;
      data_bit_q  <= data_bit_d;
    end
  end

  assign ws_change = (ws_bit_q != ws_last_q);
  assign word      = {shift_q[14:0], data_bit_q};

  // The bit at a WS change is the LSB of the word that is ending, so it closes the word.
  always_comb begin
    state_d       = state_q;
    ws_last_d     = ws_last_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    left_hold_d   = left_hold_q;
    left_ok_d     = left_ok_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    if (bit_evt_q) begin
      ws_last_d = ws_bit_q;
      case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (ws_change) begin
            bit_cnt_d = '0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (ws_change) begin
            bit_cnt_d = '0;
            if (bit_cnt_q == 5'd15) begin
              if (!ws_last_q) begin
                left_hold_d = word;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                push      = 1'b1;
                left_ok_d = 1'b0;
              end
            end else begin
              frame_err_set = 1'b1;
              left_ok_d     = 1'b0;
            end
          end else begin
            shift_d   = word;
            bit_cnt_d = (bit_cnt_q == 5'd17) ? bit_cnt_q : bit_cnt_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ws_last_q   <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_last_q   <= ws_last_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = OutputRead & ~empty;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    wr_en        = push & (~full | pop);
    overflow_set = push & full & ~pop;
    wr_ptr_d     = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = {left_hold_q, word};
    end
    overflow_d  = overflow_set | (overflow_q & ~ClearFlags);
    frame_err_d = frame_err_set | (frame_err_q & ~ClearFlags);
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign OutputData  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign OutputValid = ~empty;
  assign Overflow    = overflow_q;
  assign FrameError  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: a word-level model fills an expected-frame queue
// while a separate monitor process drains the DUT and compares every popped frame.
module tb_i2s_rx;

  localparam int DEPTH       = 4;
  localparam int HOOK_NONE   = 0;
  localparam int HOOK_POP    = 1;
  localparam int HOOK_CLEAR  = 2;
  localparam int HOOK_TIMING = 3;

  logic        MasterCLK  = 1'b0;
  logic        Reset      = 1'b0;
  logic        I2S_CLK    = 1'b0;
  logic        I2S_WS     = 1'b0;
  logic        I2S_DATA   = 1'b0;
  logic        OutputRead = 1'b0;
  logic        ClearFlags = 1'b0;
  logic [31:0] OutputData;
  logic        OutputValid;
  logic        Overflow;
  logic        FrameError;

  int          vectorsApplied = 0;
  int          miscompares    = 0;
  logic [31:0] expQ[$];
  bit          readAll        = 1'b0;
  int          popBudget      = 0;
  bit          expOverflow    = 1'b0;
  bit          expFrameError  = 1'b0;
  bit          leftPending    = 1'b0;
  logic [15:0] leftHold       = '0;
  int          lens[5]        = '{15, 16, 16, 16, 17};

  always #5 MasterCLK = ~MasterCLK;

  i2s_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .MasterCLK  (MasterCLK),
    .Reset      (Reset),
    .I2S_CLK    (I2S_CLK),
    .I2S_WS     (I2S_WS),
    .I2S_DATA   (I2S_DATA),
    .OutputData (OutputData),
    .OutputValid(OutputValid),
    .OutputRead (OutputRead),
    .ClearFlags (ClearFlags),
    .Overflow   (Overflow),
    .FrameError (FrameError)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, " Overflow"}, {31'd0, Overflow}, {31'd0, expOverflow});
    checkOutput({tag, " FrameError"}, {31'd0, FrameError}, {31'd0, expFrameError});
  endtask

  // One bit clock: WS/DATA change on the falling edge, rise 4 MasterCLK cycles later.
  // Returns on the third MasterCLK edge after the rise.
  task automatic bitEvent(input logic ws, input logic d);
    @(posedge MasterCLK); #2;
    I2S_CLK  = 1'b0;
    I2S_WS   = ws;
    I2S_DATA = d;
    repeat (4) @(posedge MasterCLK); #2;
    I2S_CLK = 1'b1;
    repeat (3) @(posedge MasterCLK);
  endtask

  // Reference model at word granularity: a word is good iff it has 16 bits.
  task automatic modelWord(input logic ch, input logic [15:0] w, input int nbits);
    if (nbits != 16) begin
      expFrameError = 1'b1;
      leftPending   = 1'b0;
    end else if (ch == 1'b0) begin
      leftHold    = w;
      leftPending = 1'b1;
    end else if (leftPending) begin
      leftPending = 1'b0;
      if (expQ.size() < DEPTH) expQ.push_back({leftHold, w});
      else expOverflow = 1'b1;
    end
  endtask

  // Philips format: bits MSB..1 carry this channel's WS, the LSB already carries the next one.
  task automatic sendWord(input logic ch, input logic [31:0] w, input int nbits, input int hook);
    for (int i = nbits - 1; i >= 1; i--) bitEvent(ch, w[i]);
    bitEvent(~ch, w[0]);
    #1;
    if (hook == HOOK_POP) popBudget = 1;
    if (hook == HOOK_CLEAR) ClearFlags = 1'b1;
    if (hook == HOOK_TIMING) checkOutput("valid before push", {31'd0, OutputValid}, 32'd0);
    @(posedge MasterCLK); #1;
    if (hook == HOOK_TIMING) checkOutput("valid one cycle after event", {31'd0, OutputValid}, 32'd1);
    if (hook == HOOK_CLEAR) begin
      ClearFlags    = 1'b0;
      expOverflow   = 1'b0;
      expFrameError = 1'b0;
    end
    modelWord(ch, w[15:0], nbits);
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r,
                               input int lbits, input int rbits, input int hook);
    sendWord(1'b0, {16'd0, l}, lbits, HOOK_NONE);
    sendWord(1'b1, {16'd0, r}, rbits, hook);
  endtask

  task automatic syncPreamble();
    for (int i = 0; i < 15; i++) bitEvent(1'b1, 1'($urandom));
    bitEvent(1'b0, 1'($urandom));
    leftPending = 1'b0;
  endtask

  task automatic pulseClear();
    @(posedge MasterCLK); #1;
    ClearFlags = 1'b1;
    @(posedge MasterCLK); #1;
    ClearFlags    = 1'b0;
    expOverflow   = 1'b0;
    expFrameError = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(posedge MasterCLK); #1;
    readAll = 1'b1;
    repeat (DEPTH + 6) @(posedge MasterCLK);
    #1;
    readAll = 1'b0;
    checkOutput({tag, " frames left"}, 32'(expQ.size()), 32'd0);
    @(posedge MasterCLK); #1;
    checkOutput({tag, " valid after drain"}, {31'd0, OutputValid}, 32'd0);
  endtask

  // Monitor: pops whenever reads are enabled and the DUT shows a frame.
  initial begin
    forever begin
      @(negedge MasterCLK);
      if (Reset && OutputValid && (readAll || popBudget > 0)) begin
        if (expQ.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL unexpected frame: got %h, expected none", OutputData);
        end else begin
          checkOutput("pop data", OutputData, expQ.pop_front());
        end
        if (popBudget > 0) popBudget--;
        OutputRead = 1'b1;
      end else begin
        OutputRead = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] l;
    logic [15:0] r;

    #12;
    checkOutput("reset OutputData", OutputData, 32'd0);
    checkOutput("reset OutputValid", {31'd0, OutputValid}, 32'd0);
    checkFlags("reset");
    @(posedge MasterCLK); #3;
    Reset = 1'b1;

    $display("[TB] clean stream");
    syncPreamble();
    applyStimulus(16'hA5C3, 16'h1234, 16, 16, HOOK_NONE);
    applyStimulus(16'h0001, 16'hFFFF, 16, 16, HOOK_NONE);
    for (int i = 0; i < 2; i++) applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_NONE);
    checkOutput("head is first frame", OutputData, 32'hA5C31234);
    checkFlags("clean");
    drain("clean");

    $display("[TB] valid timing");
    applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_TIMING);
    drain("timing");

    $display("[TB] overflow");
    for (int i = 0; i < 5; i++) applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_NONE);
    checkFlags("after 5 frames");
    pulseClear();
    checkFlags("after clear");
    applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_POP);
    checkFlags("pop with push");
    applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_CLEAR);
    checkFlags("clear vs drop");
    drain("overflow");
    pulseClear();

    $display("[TB] framing error");
    applyStimulus(16'($urandom), 16'($urandom), 15, 16, HOOK_NONE);
    checkFlags("short left");
    applyStimulus(16'hBEEF, 16'hCAFE, 16, 16, HOOK_NONE);
    checkOutput("frame after error", OutputData, 32'hBEEFCAFE);
    drain("framing");
    pulseClear();
    checkFlags("framing cleared");

    $display("[TB] random stream");
    readAll = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), lens[$urandom_range(4)], lens[$urandom_range(4)], HOOK_NONE);
      checkFlags("random");
    end
    drain("random");
    pulseClear();

    $display("[TB] reset mid-frame");
    applyStimulus(16'($urandom), 16'($urandom), 17, 16, HOOK_NONE);
    applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_NONE);
    applyStimulus(16'($urandom), 16'($urandom), 16, 16, HOOK_NONE);
    checkFlags("before reset");
    l = 16'($urandom);
    r = 16'($urandom);
    sendWord(1'b0, {16'd0, l}, 16, HOOK_NONE);
    for (int i = 15; i >= 8; i--) bitEvent(1'b1, r[i]);
    #3;
    Reset = 1'b0;
    #1;
    checkOutput("async reset OutputData", OutputData, 32'd0);
    checkOutput("async reset OutputValid", {31'd0, OutputValid}, 32'd0);
    expQ.delete();
    expOverflow   = 1'b0;
    expFrameError = 1'b0;
    leftPending   = 1'b0;
    checkFlags("async reset");
    repeat (3) @(posedge MasterCLK);
    #3;
    Reset = 1'b1;
    for (int i = 7; i >= 1; i--) bitEvent(1'b1, r[i]);
    bitEvent(1'b0, r[0]);
    checkOutput("interrupted frame dropped", {31'd0, OutputValid}, 32'd0);
    applyStimulus(16'h1357, 16'h2468, 16, 16, HOOK_NONE);
    checkOutput("first frame after reset", OutputData, 32'h13572468);
    checkFlags("after reset");
    drain("reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver for the AudVid peripheral: the receiving end of the same Philips-format serial audio link our `I2S` transmitter drives toward the DAC. It oversamples an externally clocked stereo stream (bit clock, word select, data) on `MasterCLK`, deserialises 16-bit left/right words, and packs each stereo frame into a 32-bit word `{left, right}`. Completed frames go into a small show-ahead FIFO that the processor or audio mixer drains with a valid/read handshake. Overflow and framing errors are reported through sticky flags.

## Interface

- `FIFO_DEPTH`, default 4: number of 32-bit frame entries. Must be a power of 2, minimum 2.
- `SYNC_STAGES`, default 2: synchroniser flip-flops on each serial input. Minimum 2.

Ports:

- `MasterCLK`, in, 1: the single clock (100 MHz). All state is on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `I2S_CLK`, in, 1: external bit clock, asynchronous to `MasterCLK`.
- `I2S_WS`, in, 1: word select. 0 = left, 1 = right.
- `I2S_DATA`, in, 1: serial data, MSB first.
- `OutputData`, out, 32: FIFO head, formatted `{left[15:0], right[15:0]}`.
- `OutputValid`, out, 1: FIFO not empty.
- `OutputRead`, in, 1: pop request. It is honoured only while `OutputValid` is 1.
- `ClearFlags`, in, 1: single-cycle pulse that clears `Overflow` and `FrameError`.
- `Overflow`, out, 1: sticky. A frame was dropped because the FIFO was full.
- `FrameError`, out, 1: sticky. A channel word did not contain exactly 16 bits.

## Operation

- **Input sampling.** Each serial input passes through `SYNC_STAGES` flip-flops. A bit-clock rising edge is detected as synced `I2S_CLK` = 1 while the previous synced value = 0. `I2S_WS` and `I2S_DATA` are sampled (synced values) only on a detected rising edge, called a "bit event".
- **Word boundaries.** `ws_last` holds the WS value from the previous bit event. A "WS change" is a bit event where the sampled WS differs from `ws_last`. In Philips format, the data bit at a WS-change event is the LSB of the word that is ending.
- **State machine** (reset to IDLE):
  - IDLE: on the first bit event, load `ws_last`, then go to SYNC. No data is kept.
  - SYNC: on a WS change, clear `bit_cnt`, then go to RUN. Non-change events are ignored.
  - RUN, non-change event: shift the data bit into a 16-bit shift register. `bit_cnt` increments and saturates at 17.
  - RUN, WS-change event: the candidate word is `{shift[14:0], data}`. It is valid only if `bit_cnt` = 15.
    - Valid and the ending channel was left (`ws_last` = 0): load `left_hold` and set `left_ok`.
    - Valid, the ending channel was right, and `left_ok` = 1: push `{left_hold, word}` into the FIFO and clear `left_ok`.
    - Invalid: set `FrameError`, clear `left_ok`, discard the word.
    - In all three cases: `bit_cnt` is cleared and the state stays RUN.
  - A right word that completes while `left_ok` = 0 is discarded silently. This keeps frames aligned after sync or after an error.
- **FIFO.** Show-ahead: `OutputData` always presents the head entry.
  - Pop: `OutputRead` = 1 while `OutputValid` = 1. Pop while empty is a no-op.
  - Push while full and no pop in the same cycle: the frame is dropped and `Overflow` is set.
  - Push and pop in the same cycle while full: both succeed and `Overflow` does not set.
  - Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap modulo 2·`FIFO_DEPTH`. Full and empty are distinguished by the extra MSB.
- **Flags.** A set condition and `ClearFlags` in the same cycle leave the flag at 1; set wins.
- **Reset** is asserted asynchronously, including mid-frame. It clears the synchronisers, shift register, `bit_cnt`, `left_hold`, `left_ok`, and FIFO pointers, and returns the state to IDLE. The partial frame in progress is lost.

## Timing

- Output reset values: `OutputData` = 0, `OutputValid` = 0, `Overflow` = 0, `FrameError` = 0.
- Input requirement: `I2S_CLK` high and low phases must each be ≥ `SYNC_STAGES`+1 `MasterCLK` periods. At 100 MHz with a 1.312 MHz bit clock (41 kHz × 32) there is ample margin. WS and DATA must be stable from the falling edge to the rising edge of `I2S_CLK`.
- Bit event latency: the bit event fires `SYNC_STAGES`+1 cycles after the pin-level rise. This is 3 cycles at the default.
- Push latency: the FIFO write occurs on the bit-event cycle of the right LSB. `OutputValid`/`OutputData` update on the following cycle.
- Pop: the head updates and `OutputValid` drops on the cycle after the pop edge. Back-to-back pops on consecutive cycles are supported.
- Frame format: 32 bit clocks per stereo frame, 16 per channel. A channel word with fewer or more than 16 bits is an error.

## Test plan

- **Clean stream:** reset, then 4 clean frames with L=16'hA5C3/R=16'h1234, then L=16'h0001/R=16'hFFFF, and so on, with `OutputRead` held at 0.
  - First frame after sync is discarded only if it is partial.
  - Reads then return 32'hA5C31234 first, in order. `Overflow` = 0, `FrameError` = 0.
- **Valid timing:** measure `OutputValid` rising exactly 1 cycle after the bit event of the right LSB (pin rise + 4 cycles at default). Pops on consecutive cycles drain entries in order, with `OutputValid` = 0 after the last.
- **Overflow:** with `FIFO_DEPTH` = 4, send 5 frames without reads.
  - The 4 entries are frames 1–4. `Overflow` = 1 and frame 5 is lost.
  - Then pop while frame 6 completes in the same cycle: frame 6 is accepted and the FIFO stays full.
- **Framing error:** a left word with only 15 bits sets `FrameError` = 1 and its frame is not pushed. The next clean frame, 16'hBEEF/16'hCAFE, is pushed as 32'hBEEFCAFE. `ClearFlags` then returns `FrameError` to 0.
- **Reset mid-frame:** drop `Reset` mid right word with 2 entries queued.
  - All outputs go to 0 immediately, without waiting for a clock.
  - After release, the interrupted frame is not pushed. The first complete `{L,R}` frame that follows two WS changes is captured correctly.
- **Flag priority:** `ClearFlags` pulsed in the same cycle as an overflow drop leaves `Overflow` = 1.
